mem_write_arbiter: RTL
======================

Name: mem_write_arbiter

Overview:
- Shares the single write port of the word-addressed data memory between two requesters: port 0 is the core store path, port 1 is the loader/debug path.
- Round-robin arbitration, with an optional lock so one requester can hold the port for back-to-back beats.
- Registered write issue.
- Detects a nonzero write to the last (mailbox) word, then halts all writes until software/bench clears it.

Parameters:
- pWords, 32'd44, memory depth in 32-bit words. Mailbox word index = pWords-1 (byte address (pWords-1)*4).

Ports:
- iwClk  input  1  clock. All state updates on the rising edge.
- iwRst  input  1  reset, asynchronous, active-high.
- iwValid0  input  1  port 0 write request.
- iwAddr0  input  32  port 0 byte address.
- iwData0  input  32  port 0 write data.
- iwWstrb0  input  4  port 0 byte strobes.
- iwLock0  input  1  port 0 requests to keep the grant after this beat.
- owReady0  output  1  port 0 beat accepted this cycle (combinational).
- iwValid1, iwAddr1, iwData1, iwWstrb1, iwLock1, owReady1: port 1, identical to port 0.
- owMemWriteAddr  output  32  byte address to memory.
- owMemWriteData  output  32  data to memory.
- owMemWstrb  output  4  strobes to memory; 4'b0 means no write.
- owDone  output  1  sticky mailbox-written flag.
- owErr  output  1  one-cycle pulse: an accepted beat was out of range and was dropped.
- iwClearDone  input  1  clears owDone and leaves HALT.

Behaviour:
- Reset (iwRst=1, async): state ARB, rr pointer = 0 (port 0 preferred), owMemWriteAddr=0, owMemWriteData=0, owMemWstrb=0, owDone=0, owErr=0.
- States: ARB, LOCK0, LOCK1, HALT.
- ARB, grant rule:
  - Only one valid: grant it.
  - Both valid: grant the port not granted last (rr pointer).
  - owReadyN = grantN & iwValidN. At most one ready is high per cycle.
- A beat is accepted when owReadyN & iwValidN at the rising edge. The rr pointer then updates to the other port.
- Locking:
  - Accepted beat with iwLockN=1: go to LOCKN.
  - In LOCKN: only port N may be ready. The other port is stalled even if valid.
  - LOCKN returns to ARB when port N has an accepted beat with iwLockN=0.
  - LOCKN also returns to ARB when port N drops iwValidN and iwLockN together.
- Latency: an accepted beat drives owMemWriteAddr/Data/Wstrb on the next cycle, for exactly one cycle. Otherwise owMemWstrb=0; addr/data hold their last value.
- Throughput: one beat per cycle.
- Range check: (addr>>2) >= pWords means the beat is still accepted (ready high) but owMemWstrb=0 next cycle. owErr pulses high for that cycle.
- Unaligned addresses: low two bits are passed through unchanged; memory ignores them.
- Mailbox trigger: accepted, in-range beat with (addr>>2)==pWords-1, wstrb!=0, and (data masked by wstrb)!=0.
  - The write itself is issued normally.
  - owDone goes 1 in the same cycle the write appears on the memory port.
  - State goes to HALT. This takes priority over entering LOCKN.
- HALT: both readies 0; owMemWstrb=0 after the final write. Stays until iwClearDone=1 at a rising edge, then ARB with owDone=0. The rr pointer is retained.
- iwClearDone outside HALT: clears owDone only, no other effect.
- Simultaneous mailbox trigger and iwClearDone in the same cycle: the trigger wins (HALT, owDone=1).
- Reset mid-lock or mid-HALT: immediate return to reset values. Any beat issued in that cycle is lost.

Test Plan:
- Reset mid-stream: assert iwRst while port 1 is streaming -> owMemWstrb=0, owDone=0, state ARB immediately, no clock needed. After release, the first contention grants port 0.
- Single requester: port 0 valid, addr 0x10, data 0xDEADBEEF, wstrb 4'hF -> owReady0=1 in cycle 0; cycle 1 shows owMemWriteAddr=0x10, owMemWriteData=0xDEADBEEF, owMemWstrb=4'hF; cycle 2 owMemWstrb=0.
- Contention: both valid continuously with distinct addresses -> grants alternate 0,1,0,1, one memory write per cycle, no beat lost or duplicated.
- Lock: port 1 sends 3 beats with lock=1,1,0 while port 0 is valid -> owReady0=0 for all three; port 0 is granted on the 4th cycle.
- Range error: port 0 writes addr 0xB0 (word 44, pWords=44) -> owReady0=1, next cycle owMemWstrb=0 and owErr=1 for one cycle; owDone unchanged.
- Mailbox: port 1 writes addr 0xAC, data 0x00000001, wstrb 4'h1 -> write issued, owDone=1, both readies 0 while valid. Pulse iwClearDone -> owDone=0, arbitration resumes. Same address with data 0 -> no halt.

Source files
------------

// File: rtl/mem_write_arbiter.sv
// Two-port round-robin arbiter (with optional lock) onto the single data-memory write port.
// Latency: one cycle from accepted beat to memory write; halts after a nonzero mailbox write.
module mem_write_arbiter #(
    parameter logic [31:0] pWords = 32'd44
) (
    input  logic        iwClk,
    input  logic        iwRst,
    input  logic        iwValid0,
    input  logic [31:0] iwAddr0,
    input  logic [31:0] iwData0,
    input  logic [3:0]  iwWstrb0,
    input  logic        iwLock0,
    output logic        owReady0,
    input  logic        iwValid1,
    input  logic [31:0] iwAddr1,
    input  logic [31:0] iwData1,
    input  logic [3:0]  iwWstrb1,
    input  logic        iwLock1,
    output logic        owReady1,
    output logic [31:0] owMemWriteAddr,
    output logic [31:0] owMemWriteData,
    output logic [3:0]  owMemWstrb,
    output logic        owDone,
    output logic        owErr,
    input  logic        iwClearDone
);

    typedef enum logic [1:0] {ARB, LOCK0, LOCK1, HALT} state_t;

    state_t      state, state_nxt;
    logic        rr, rr_nxt;
    logic        accept;
    logic [31:0] sel_addr;
    logic [31:0] sel_data;
    logic [3:0]  sel_wstrb;
    logic        sel_lock;
    logic [31:0] word_idx;
    logic [31:0] byte_mask;
    logic        in_range;
    logic        trigger;

    always_comb begin
        owReady0 = 1'b0;
        owReady1 = 1'b0;
        case (state)
            ARB: begin
                // rr names the port preferred on contention
                if (iwValid0 && iwValid1) begin
                    owReady0 = !rr;
                    owReady1 = rr;
                end else begin
                    owReady0 = iwValid0;
                    owReady1 = iwValid1;
                end
            end
            LOCK0:   owReady0 = iwValid0;
            LOCK1:   owReady1 = iwValid1;
            default: ;
        endcase
    end

    assign accept    = owReady0 | owReady1;
    assign sel_addr  = owReady1 ? iwAddr1  : iwAddr0;
    assign sel_data  = owReady1 ? iwData1  : iwData0;
    assign sel_wstrb = owReady1 ? iwWstrb1 : iwWstrb0;
    assign sel_lock  = owReady1 ? iwLock1  : iwLock0;
    assign word_idx  = {2'b00, sel_addr[31:2]};
    assign in_range  = word_idx < pWords;
    assign byte_mask = {{8{sel_wstrb[3]}}, {8{sel_wstrb[2]}}, {8{sel_wstrb[1]}}, {8{sel_wstrb[0]}}};
    assign trigger   = accept && in_range && (word_idx == pWords - 32'd1)
                       && (sel_wstrb != 4'h0) && ((sel_data & byte_mask) != 32'h0);

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr;
        if (accept) begin
            rr_nxt = owReady0;
        end
        case (state)
            ARB: begin
                if (accept && sel_lock) begin
                    state_nxt = owReady1 ? LOCK1 : LOCK0;
                end
            end
            // Dropping lock ends the hold whether or not a beat went through with it.
            LOCK0: if (!iwLock0) state_nxt = ARB;
            LOCK1: if (!iwLock1) state_nxt = ARB;
            HALT:  if (iwClearDone) state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
        if (trigger) begin
            state_nxt = HALT;
        end
    end

    always_ff @(posedge iwClk or posedge iwRst) begin
        if (iwRst) begin
            state          <= ARB;
            rr             <= 1'b0;
            owMemWriteAddr <= 32'h0;
            owMemWriteData <= 32'h0;
            owMemWstrb     <= 4'h0;
            owDone         <= 1'b0;
            owErr          <= 1'b0;
        end else begin
            state <= state_nxt;
            rr    <= rr_nxt;
            owErr <= accept && !in_range;
            if (accept && in_range) begin
                owMemWriteAddr <= sel_addr;
                owMemWriteData <= sel_data;
                owMemWstrb     <= sel_wstrb;
            end else begin
                owMemWstrb <= 4'h0;
            end
            if (trigger) begin
                owDone <= 1'b1;
            end else if (iwClearDone) begin
                owDone <= 1'b0;
            end
        end
    end

endmodule
